// File: rtl/if_prefetch_stage.sv
// ============================================================================
// if_prefetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the fetch PC,
// issues word requests to instruction memory over a req/gnt/rvalid handshake
// (at most one request outstanding) and buffers returned instructions in a
// DEPTH-entry prefetch queue that the IF/ID register consumes from.
// A taken branch/jump from EX (PCSrc_i) flushes the queue, redirects the fetch
// PC and discards any response still in flight for the old path.
//
// Optional feature macro: IF_PERF_CNT_EN
//   When defined, adds the saturating counters fetch_cnt_o, flush_cnt_o and
//   drop_cnt_o. Functional behaviour is identical either way.
//
// Ports:
//   clk_i              clock, rising edge
//   reset_i            asynchronous active-high reset
//   pipeline_stall_i   hazard-unit stall; blocks popping the queue
//   PCSrc_i            redirect request from EX
//   PC_branch_i[31:0]  redirect target (bits [1:0] ignored)
//   imem_req_o         fetch request valid
//   imem_addr_o[31:0]  fetch word address
//   imem_gnt_i         memory accepts the request this cycle
//   imem_rvalid_i      response valid
//   imem_rdata_i[31:0] instruction word returned with imem_rvalid_i
//   if_valid_o         queue head valid
//   PC_IF_o[31:0]      PC of the queue head (0 when empty)
//   INSTRUCTION_IF_o   instruction at the queue head (NOP_INSTR when empty)
//   fetch_cnt_o, flush_cnt_o, drop_cnt_o  (IF_PERF_CNT_EN only)
// ============================================================================
module if_prefetch_stage #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pipeline_stall_i,
    input  logic        PCSrc_i,
    input  logic [31:0] PC_branch_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] PC_IF_o,
    output logic [31:0] INSTRUCTION_IF_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] drop_cnt_o
`endif
);

    localparam int unsigned     PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW+1:0]   DEPTH_W = (PW+2)'(DEPTH);

    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DROP} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, tail_q;
    logic [PW:0]     count_q;
    logic [31:0]     pc_buf_q    [DEPTH];
    logic [31:0]     instr_buf_q [DEPTH];

    logic            outstanding;
    logic            room;
    logic            req;
    logic            accept;
    logic            push;
    logic            pop;
    logic [31:0]     branch_tgt;

    assign outstanding = (state_q != ST_FETCH);
    // Reserve a slot for the in-flight response so it can always be queued.
    assign room        = ({1'b0, count_q} + {{(PW+1){1'b0}}, outstanding}) < DEPTH_W;
    assign accept      = req & imem_gnt_i;
    assign push        = (state_q == ST_WAIT) && imem_rvalid_i && !PCSrc_i;
    assign pop         = (count_q != '0) && !pipeline_stall_i && !PCSrc_i;
    assign branch_tgt  = PC_branch_i & ~32'h3;

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A redirect goes to DROP only if a response will still
    // arrive afterwards; one returning in the redirect cycle is simply ignored.
    always_comb begin
        state_d = state_q;
        if (PCSrc_i) begin
            state_d = ((outstanding && !imem_rvalid_i) || accept) ? ST_DROP : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: if (accept) state_d = ST_WAIT;
                ST_WAIT:  if (imem_rvalid_i) state_d = accept ? ST_WAIT : ST_FETCH;
                ST_DROP:  if (imem_rvalid_i) state_d = ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    // FSM outputs. Requesting in WAIT during the response cycle gives
    // back-to-back fetches with a single-cycle memory.
    always_comb begin
        req = 1'b0;
        if (!reset_i && !PCSrc_i && room) begin
            if (state_q == ST_FETCH) begin
                req = 1'b1;
            end else if ((state_q == ST_WAIT) && imem_rvalid_i) begin
                req = 1'b1;
            end
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (PCSrc_i) begin
            fetch_pc_d = branch_tgt;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // Fetch PC and queue pointers; a redirect empties the queue outright.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (PCSrc_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PW'(1);
                if (pop)  head_q <= head_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + (PW+1)'(1);
                    2'b01:   count_q <= count_q - (PW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Queue storage. While in WAIT the fetch PC has already advanced past the
    // outstanding request, so that request's PC is fetch_pc - 4.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_buf_q[tail_q]    <= fetch_pc_q - 32'd4;
            instr_buf_q[tail_q] <= imem_rdata_i;
        end
    end

    assign imem_req_o       = req;
    assign imem_addr_o      = fetch_pc_q;
    assign if_valid_o       = (count_q != '0);
    assign PC_IF_o          = if_valid_o ? pc_buf_q[head_q]    : 32'h0;
    assign INSTRUCTION_IF_o = if_valid_o ? instr_buf_q[head_q] : NOP_INSTR;

`ifdef IF_PERF_CNT_EN
    logic        drop_evt;
    logic [31:0] fetch_cnt_q, flush_cnt_q, drop_cnt_q;

    assign drop_evt = imem_rvalid_i &&
                      ((state_q == ST_DROP) || ((state_q == ST_WAIT) && PCSrc_i));

    // Saturating event counters.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (accept   && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (PCSrc_i  && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (drop_evt && (drop_cnt_q  != '1)) drop_cnt_q  <= drop_cnt_q  + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ============================================================================
// tb_if_prefetch_stage
// ----------------------------------------------------------------------------
// Bench for if_prefetch_stage. A behavioural instruction memory answers each
// accepted request after a programmable latency with data addr | 0x1000.
// Returned words that the stage should keep are pushed to an expected queue;
// the queue head is compared against PC_IF/INSTRUCTION_IF every cycle.
// All inputs are driven on the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
// ============================================================================
module tb_if_prefetch_stage;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pcsrc;
    logic [31:0] branch;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ifValid;
    logic [31:0] pcIf;
    logic [31:0] instrIf;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCntO, flushCntO, dropCntO;
`endif

    // Expected-result scoreboard and memory-model state.
    entry_t      expQ[$];
    logic        pending;
    logic        pendDrop;
    logic [31:0] pendAddr;
    int          pendWait;
    logic [31:0] expFetchPc;
    bit          gntRandom;
    int          latMin, latMax;
    logic        sampledReq;
    logic        acceptSeen;
    logic [31:0] sampledAddr;
    int          fetchCnt, flushCnt, dropCnt;

    int          vectors;
    int          miscompares;
    logic        found;

    if_prefetch_stage #(
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .pipeline_stall_i (stall),
        .PCSrc_i          (pcsrc),
        .PC_branch_i      (branch),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_gnt_i       (gnt),
        .imem_rvalid_i    (rvalid),
        .imem_rdata_i     (rdata),
        .if_valid_o       (ifValid),
        .PC_IF_o          (pcIf),
        .INSTRUCTION_IF_o (instrIf)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o      (fetchCntO),
        .flush_cnt_o      (flushCntO),
        .drop_cnt_o       (dropCntO)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a | 32'h0000_1000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        pending    = 1'b0;
        pendDrop   = 1'b0;
        pendAddr   = 32'h0;
        pendWait   = 0;
        expFetchPc = 32'h0;
        fetchCnt   = 0;
        flushCnt   = 0;
        dropCnt    = 0;
    endtask

    // Holds reset across one rising edge, checks the reset state, and returns
    // mid-cycle with reset released (cycle 0 starts here).
    task automatic doReset();
        reset  = 1'b1;
        stall  = 1'b0;
        pcsrc  = 1'b0;
        branch = 32'h0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        resetModel();
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req", req, 1'b0);
        checkOutput("reset_if_valid", ifValid, 1'b0);
        checkOutput("reset_pc_if", pcIf, 32'h0);
        checkOutput("reset_instr_if", instrIf, NOP);
        reset = 1'b0;
    endtask

    // One clock cycle: drive the memory, check outputs against the scoreboard,
    // then advance the model across the rising edge.
    task automatic applyStimulus();
        logic rvNow;
        logic expReq;
        logic doPop;
        int   qsz;
        entry_t e;

        rvNow  = pending && (pendWait == 0);
        rvalid = rvNow;
        rdata  = rvNow ? memData(pendAddr) : $urandom;
        gnt    = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;

        qsz = expQ.size();
        checkOutput("if_valid", ifValid, qsz != 0);
        checkOutput("PC_IF", pcIf, (qsz != 0) ? expQ[0].pc : 32'h0);
        checkOutput("INSTRUCTION_IF", instrIf, (qsz != 0) ? expQ[0].instr : NOP);
        expReq = !pcsrc && (!pending || (rvNow && !pendDrop)) &&
                 ((qsz + int'(pending)) < DEPTH);
        checkOutput("imem_req", req, expReq);
        sampledReq  = req;
        sampledAddr = addr;
        acceptSeen  = req && gnt;
        if (req) checkOutput("imem_addr", addr, expFetchPc);

        doPop = (qsz != 0) && !stall && !pcsrc;
        if (pending && !rvNow) pendWait--;
        if (doPop) void'(expQ.pop_front());
        if (rvNow) begin
            if (!pendDrop && !pcsrc) begin
                e.pc    = pendAddr;
                e.instr = memData(pendAddr);
                expQ.push_back(e);
            end else begin
                dropCnt++;
            end
            pending = 1'b0;
        end
        if (acceptSeen) begin
            fetchCnt++;
            expFetchPc = expFetchPc + 32'd4;
            pending    = 1'b1;
            pendDrop   = 1'b0;
            pendAddr   = addr;
            pendWait   = $urandom_range(latMin, latMax) - 1;
        end
        if (pcsrc) begin
            flushCnt++;
            expQ.delete();
            if (pending) pendDrop = 1'b1;
            expFetchPc = branch & ~32'h3;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        gntRandom   = 1'b0;
        latMin      = 1;
        latMax      = 1;
        sampledReq  = 1'b0;
        acceptSeen  = 1'b0;
        sampledAddr = 32'h0;

        // Streaming with a single-cycle memory: first valid in cycle 2.
        doReset();
        applyStimulus();
        applyStimulus();
        checkOutput("first_valid_c2", ifValid, 1'b1);
        checkOutput("first_pc_c2", pcIf, 32'h0);
        checkOutput("first_instr_c2", instrIf, 32'h0000_1000);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus();
            checkOutput("stream_pc", pcIf, 32'(4 * k));
        end

        // Stall: queue fills, requests stop, head is frozen.
        stall = 1'b1;
        repeat (10) applyStimulus();
        checkOutput("stall_frozen_pc", pcIf, 32'hC);
        checkOutput("stall_req_low", sampledReq, 1'b0);
        stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checkOutput("drain_pc", pcIf, 32'(12 + 4 * k));
            applyStimulus();
        end

        // Redirect while the request to 0x10 is outstanding.
        doReset();
        latMin = 3;
        latMax = 3;
        found  = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            applyStimulus();
            if (pending && !pendDrop && (pendAddr == 32'h10)) found = 1'b1;
        end
        checkOutput("find_req_0x10", found, 1'b1);
        pcsrc  = 1'b1;
        branch = 32'h203;
        applyStimulus();
        pcsrc  = 1'b0;
        checkOutput("redir_valid_low", ifValid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus();
            if (acceptSeen) found = 1'b1;
        end
        checkOutput("redir_accept_seen", found, 1'b1);
        checkOutput("redir_first_addr", sampledAddr, 32'h200);
        for (int i = 0; i < 30 && !ifValid; i++) applyStimulus();
        checkOutput("redir_first_pc", pcIf, 32'h200);
        checkOutput("redir_first_instr", instrIf, 32'h0000_1200);

        // Redirect coinciding with the response that would fill the queue.
        doReset();
        latMin = 2;
        latMax = 2;
        stall  = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if ((expQ.size() == DEPTH - 1) && pending && !pendDrop && (pendWait == 0))
                found = 1'b1;
            else
                applyStimulus();
        end
        checkOutput("full_setup", found, 1'b1);
        pcsrc  = 1'b1;
        branch = 32'h340;
        applyStimulus();
        pcsrc  = 1'b0;
        stall  = 1'b0;
        checkOutput("coinc_valid_low", ifValid, 1'b0);
        applyStimulus();
        checkOutput("coinc_req", sampledReq, 1'b1);
        checkOutput("coinc_addr", sampledAddr, 32'h340);

        // Random grant, latency, stalls and redirects.
        doReset();
        gntRandom = 1'b1;
        latMin    = 1;
        latMax    = 5;
        repeat (800) begin
            stall  = ($urandom_range(0, 3) == 0);
            pcsrc  = ($urandom_range(0, 39) == 0);
            branch = {18'h0, 14'($urandom)};
            applyStimulus();
        end
        pcsrc = 1'b0;
        stall = 1'b0;

`ifdef IF_PERF_CNT_EN
        checkOutput("fetch_cnt", fetchCntO, 32'(fetchCnt));
        checkOutput("flush_cnt", flushCntO, 32'(flushCnt));
        checkOutput("drop_cnt", dropCntO, 32'(dropCnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
